biriscv_alu_pipe: RTL and testbench
===================================

Name: biriscv_alu_pipe

Overview:
Parametrised, pipelined integer ALU for the execute stage, generalising the single-cycle combinational ALU to WIDTH-bit datapaths (32 or 64). Adds rotate and signed min/max operations. Adds a valid/ready elastic pipeline of 1 or 2 register stages, with tag passthrough and a flush for mispredict recovery. Sits between issue and writeback; one op accepted per cycle at full throughput.

Parameters:
WIDTH, 32, datapath width; legal values 32 or 64; shift amount uses the low log2(WIDTH) bits of operand B.
PIPE_STAGES, 1, register stages (1 or 2); also the latency in cycles from accept to out_valid_o when unstalled.
TAG_W, 4, width of the opaque tag carried alongside each op.

Ports:
clk_i  input  1  clock; all state updates on rising edge.
rst_ni  input  1  reset, synchronous, active-low.
flush_i  input  1  kill all in-flight ops and any op presented this cycle.
in_valid_i  input  1  op present on inputs.
in_ready_o  output  1  block can accept an op this cycle.
alu_op_i  input  4  operation code (encoding below).
alu_a_i  input  WIDTH  operand A.
alu_b_i  input  WIDTH  operand B / shift amount.
in_tag_i  input  TAG_W  tag returned with the result.
out_valid_o  output  1  result valid.
out_ready_i  input  1  consumer takes the result this cycle.
out_result_o  output  WIDTH  result.
out_tag_o  output  TAG_W  tag of the op producing out_result_o.

Behaviour:
- Op encoding, with sh = B[log2(WIDTH)-1:0]:
  - 0: pass A.
  - 1: SLL, A<<sh.
  - 2: SRL, zero fill.
  - 3: SRA, fill with A[WIDTH-1].
  - 4: ADD, modulo 2^WIDTH.
  - 5: ROTL by sh.
  - 6: SUB, A-B modulo 2^WIDTH.
  - 7: AND. 8: OR. 9: XOR.
  - 10: SLTU, result = zero-extended 1 bit.
  - 11: SLT, signed compare.
  - 12: ROTR by sh.
  - 13: MIN, signed.
  - 14: MAX, signed.
  - 15: pass A (reserved).
- Accept: a transfer occurs when in_valid_i & in_ready_o & ~flush_i.
- Out handshake: a transfer occurs when out_valid_o & out_ready_i.
- Pipeline structure, per stage: valid bit plus payload. Stage advances when it is empty or the next stage/consumer takes its content that cycle.
  - PIPE_STAGES=1: result computed from inputs and registered into the output stage.
  - PIPE_STAGES=2: stage 1 registers op, A, B and tag; stage 2 computes and registers result and tag.
- in_ready_o = ~stage1_valid | stage1 advancing. It is combinational from out_ready_i (ready chain). It does not depend on in_valid_i.
- Latency and throughput: with out_ready_i held high, the result appears exactly PIPE_STAGES cycles after accept. Sustained throughput is 1 op/cycle with no bubbles.
- Backpressure: while out_valid_o & ~out_ready_i, out_result_o and out_tag_o stay stable. No op is lost or duplicated, and ordering is strictly FIFO.
- Flush: on a cycle with flush_i=1, all stage valid bits clear at the next edge and the input presented that cycle is discarded.
  - Flush wins over a simultaneous accept and over a simultaneous out handshake. The consumer may sample out_valid_o/out_result_o in that cycle; the block treats it as delivered.
  - in_ready_o is 1 in the cycle after a flush.
- Reset (rst_ni=0 at an edge): all valid bits 0; out_result_o=0, out_tag_o=0, internal payload registers 0. Reset mid-operation drops all in-flight ops. in_ready_o=1 from the first cycle after reset is released.
- Reset has priority over flush; flush has priority over normal advance.
- Width rules:
  - No carry or overflow output.
  - Shift/rotate by 0 returns A unchanged.
  - Upper bits of B above the shift field are ignored for ops 1, 2, 3, 5 and 12.

Test Plan:
- WIDTH=32, PIPE_STAGES=1, out_ready_i=1: ADD A=0xFFFFFFFF, B=1 -> result 0x00000000 one cycle after accept. SRA A=0x80000000, B=0x24 (sh=4) -> 0xF8000000.
- WIDTH=64: ROTL A=0x8000000000000001, sh=1 -> 0x0000000000000003. ROTR same A, sh=1 -> 0xC000000000000000. SLT A=-1, B=0 -> 1. SLTU same -> 0. MIN(-5,3) -> -5. MAX(-5,3) -> 3.
- PIPE_STAGES=2, burst of 6 back-to-back ops with tags 0..5 and out_ready_i=1: results with tags 0..5 appear on 6 consecutive cycles starting 2 cycles after the first accept.
- Backpressure: hold out_ready_i=0 for 5 cycles during a burst. in_ready_o drops once the stages fill (after PIPE_STAGES accepts). Output is stable throughout, and after release order and count are exact.
- Flush with a full pipe plus in_valid_i=1 in the same cycle: next cycle out_valid_o=0, in_ready_o=1. The dropped tags never appear.
- Assert rst_ni=0 for 1 cycle with the pipe full and stalled: next cycle out_valid_o=0, out_result_o=0, out_tag_o=0. A new op then completes with normal latency.

Source files
------------

// File: rtl/biriscv_alu_pipe.sv
// Pipelined integer ALU for the execute stage.
// WIDTH-bit datapath (32 or 64) with a 1- or 2-stage valid/ready elastic
// pipeline. An opaque tag rides alongside each op, and flush_i kills
// everything in flight for mispredict recovery.
module biriscv_alu_pipe #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned PIPE_STAGES = 1,
  parameter int unsigned TAG_W       = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       alu_op_i,
  input  logic [WIDTH-1:0] alu_a_i,
  input  logic [WIDTH-1:0] alu_b_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_result_o,
  output logic [TAG_W-1:0] out_tag_o
);

  localparam int unsigned SHW = $clog2(WIDTH);

  // Result function shared by both pipeline depths.
  function automatic logic [WIDTH-1:0] alu_calc(input logic [3:0]       op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [SHW-1:0]   sh;
    logic [SHW:0]     sh_inv;
    logic             lt_s;
    logic             lt_u;
    logic [WIDTH-1:0] res;
    sh     = b[SHW-1:0];
    // Complementary rotate amount; equals WIDTH when sh is 0, and a shift by
    // WIDTH yields 0, so rotate-by-0 returns A unchanged.
    sh_inv = (SHW+1)'(WIDTH) - {1'b0, sh};
    lt_s   = $signed(a) < $signed(b);
    lt_u   = a < b;
    res    = a;
    case (op)
      4'd0:    res = a;
      4'd1:    res = a << sh;
      4'd2:    res = a >> sh;
      4'd3:    res = $signed(a) >>> sh;
      4'd4:    res = a + b;
      4'd5:    res = (a << sh) | (a >> sh_inv);
      4'd6:    res = a - b;
      4'd7:    res = a & b;
      4'd8:    res = a | b;
      4'd9:    res = a ^ b;
      4'd10:   res = {{(WIDTH-1){1'b0}}, lt_u};
      4'd11:   res = {{(WIDTH-1){1'b0}}, lt_s};
      4'd12:   res = (a >> sh) | (a << sh_inv);
      4'd13:   res = lt_s ? a : b;
      4'd14:   res = lt_s ? b : a;
      default: res = a;
    endcase
    return res;
  endfunction

  // Output stage state.
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_result;
  logic [TAG_W-1:0] r_out_tag;

  // Handshake and output-stage load path.
  logic             w_accept;
  logic             w_out_adv;
  logic             w_load;
  logic [WIDTH-1:0] w_load_result;
  logic [TAG_W-1:0] w_load_tag;

  assign w_accept  = in_valid_i & in_ready_o & ~flush_i;
  // Output stage can take new content when empty or being drained.
  assign w_out_adv = ~r_out_valid | out_ready_i;

  assign out_valid_o  = r_out_valid;
  assign out_result_o = r_out_result;
  assign out_tag_o    = r_out_tag;

  // Output stage: reset clears, flush kills, otherwise refill on advance.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_tag    <= '0;
    end else if (flush_i) begin
      r_out_valid <= 1'b0;
    end else if (w_out_adv) begin
      r_out_valid <= w_load;
      if (w_load) begin
        r_out_result <= w_load_result;
        r_out_tag    <= w_load_tag;
      end
    end
  end

  if (PIPE_STAGES == 1) begin : g_one_stage
    // Compute straight from the inputs into the output stage.
    assign in_ready_o    = w_out_adv;
    assign w_load        = w_accept;
    assign w_load_result = alu_calc(alu_op_i, alu_a_i, alu_b_i);
    assign w_load_tag    = in_tag_i;
  end else begin : g_two_stage
    logic             r_s1_valid;
    logic [3:0]       r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [TAG_W-1:0] r_s1_tag;
    logic             w_s1_adv;

    assign w_s1_adv      = ~r_s1_valid | w_out_adv;
    assign in_ready_o    = w_s1_adv;
    assign w_load        = r_s1_valid;
    assign w_load_result = alu_calc(r_s1_op, r_s1_a, r_s1_b);
    assign w_load_tag    = r_s1_tag;

    // Operand stage: capture accepted ops, hold while the output stage stalls.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        r_s1_valid <= 1'b0;
        r_s1_op    <= '0;
        r_s1_a     <= '0;
        r_s1_b     <= '0;
        r_s1_tag   <= '0;
      end else if (flush_i) begin
        r_s1_valid <= 1'b0;
      end else if (w_s1_adv) begin
        r_s1_valid <= w_accept;
        if (w_accept) begin
          r_s1_op  <= alu_op_i;
          r_s1_a   <= alu_a_i;
          r_s1_b   <= alu_b_i;
          r_s1_tag <= in_tag_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_biriscv_alu_pipe.sv
// Directed bench: d1 is a 32-bit single-stage ALU, d2 a 64-bit two-stage ALU.
module tb_biriscv_alu_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        f1, iv1, ir1, ov1, or1;
  logic [3:0]  op1, t1i, t1o;
  logic [31:0] a1, b1, r1;

  logic        f2, iv2, ir2, ov2, or2;
  logic [3:0]  op2, t2i, t2o;
  logic [63:0] a2, b2, r2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0]  bop  [6];
  logic [63:0] ba   [6];
  logic [63:0] bb   [6];
  logic [63:0] bexp [6];

  logic [3:0]  q [$];
  int          sent, got;
  logic        hold_v;
  logic [63:0] hold_r;
  logic [3:0]  hold_t;

  biriscv_alu_pipe #(.WIDTH(32), .PIPE_STAGES(1), .TAG_W(4)) u_d1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(f1),
    .in_valid_i(iv1), .in_ready_o(ir1),
    .alu_op_i(op1), .alu_a_i(a1), .alu_b_i(b1), .in_tag_i(t1i),
    .out_valid_o(ov1), .out_ready_i(or1), .out_result_o(r1), .out_tag_o(t1o)
  );

  biriscv_alu_pipe #(.WIDTH(64), .PIPE_STAGES(2), .TAG_W(4)) u_d2 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(f2),
    .in_valid_i(iv2), .in_ready_o(ir2),
    .alu_op_i(op2), .alu_a_i(a2), .alu_b_i(b2), .in_tag_i(t2i),
    .out_valid_o(ov2), .out_ready_i(or2), .out_result_o(r2), .out_tag_o(t2o)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    f1 = 0; iv1 = 0; or1 = 1; op1 = 0; a1 = 0; b1 = 0; t1i = 0;
    f2 = 0; iv2 = 0; or2 = 1; op2 = 0; a2 = 0; b2 = 0; t2i = 0;

    bop[0] = 4'd5;  ba[0] = 64'h8000_0000_0000_0001; bb[0] = 64'hFFFF_FF00_0000_0041;
    bexp[0] = 64'h0000_0000_0000_0003;
    bop[1] = 4'd12; ba[1] = 64'h8000_0000_0000_0001; bb[1] = 64'd1;
    bexp[1] = 64'hC000_0000_0000_0000;
    bop[2] = 4'd11; ba[2] = 64'hFFFF_FFFF_FFFF_FFFF; bb[2] = 64'd0; bexp[2] = 64'd1;
    bop[3] = 4'd10; ba[3] = 64'hFFFF_FFFF_FFFF_FFFF; bb[3] = 64'd0; bexp[3] = 64'd0;
    bop[4] = 4'd13; ba[4] = 64'hFFFF_FFFF_FFFF_FFFB; bb[4] = 64'd3;
    bexp[4] = 64'hFFFF_FFFF_FFFF_FFFB;
    bop[5] = 4'd14; ba[5] = 64'hFFFF_FFFF_FFFF_FFFB; bb[5] = 64'd3; bexp[5] = 64'd3;

    // Reset and release
    step();
    step();
    rst_n = 1'b1;
    step();
    check("rst_d1_valid", ov1, 0);
    check("rst_d1_result", r1, 0);
    check("rst_d1_tag", t1o, 0);
    check("rst_d1_ready", ir1, 1);
    check("rst_d2_valid", ov2, 0);
    check("rst_d2_result", r2, 0);
    check("rst_d2_tag", t2o, 0);
    check("rst_d2_ready", ir2, 1);

    // d1: ADD wraps, result one cycle after accept
    iv1 = 1; op1 = 4'd4; a1 = 32'hFFFF_FFFF; b1 = 32'd1; t1i = 4'd3;
    #1 check("d1_add_ready", ir1, 1);
    step();
    check("d1_add_valid", ov1, 1);
    check("d1_add_result", r1, 32'h0000_0000);
    check("d1_add_tag", t1o, 4'd3);

    // d1: SRA with upper B bits ignored (sh = 4)
    op1 = 4'd3; a1 = 32'h8000_0000; b1 = 32'h0000_0024; t1i = 4'd4;
    step();
    check("d1_sra_result", r1, 32'hF800_0000);
    check("d1_sra_tag", t1o, 4'd4);

    // d1: XOR, then backpressure
    op1 = 4'd9; a1 = 32'h0F0F_0F0F; b1 = 32'hFFFF_0000; t1i = 4'd6;
    step();
    check("d1_xor_result", r1, 32'hF0F0_0F0F);
    or1 = 0; op1 = 4'd8; a1 = 32'h0000_00F0; b1 = 32'h0000_000F; t1i = 4'd7;
    #1 check("d1_bp_ready_low", ir1, 0);
    step();
    check("d1_bp_hold_result", r1, 32'hF0F0_0F0F);
    check("d1_bp_hold_tag", t1o, 4'd6);
    check("d1_bp_ready_still_low", ir1, 0);
    or1 = 1;
    #1 check("d1_bp_ready_comb", ir1, 1);
    step();
    check("d1_or_result", r1, 32'h0000_00FF);
    check("d1_or_tag", t1o, 4'd7);

    // d1: flush beats a simultaneous accept and out handshake
    op1 = 4'd6; a1 = 32'd5; b1 = 32'd7; t1i = 4'd8; f1 = 1;
    step();
    f1 = 0; iv1 = 0;
    check("d1_flush_valid", ov1, 0);
    #1 check("d1_flush_ready", ir1, 1);
    step();
    check("d1_flush_stays_empty", ov1, 0);

    // d2: back-to-back burst of six 64-bit ops, tags 0..5
    for (int i = 0; i < 7; i++) begin
      if (i < 6) begin
        iv2 = 1; op2 = bop[i]; a2 = ba[i]; b2 = bb[i]; t2i = 4'(i);
      end else begin
        iv2 = 0;
      end
      #1;
      if (i < 6) check($sformatf("burst_ready%0d", i), ir2, 1);
      step();
      if (i == 0) begin
        check("burst_latency", ov2, 0);
      end else begin
        check($sformatf("burst_valid%0d", i - 1), ov2, 1);
        check($sformatf("burst_tag%0d", i - 1), t2o, 4'(i - 1));
        check($sformatf("burst_result%0d", i - 1), r2, bexp[i - 1]);
      end
    end
    step();
    check("burst_drained", ov2, 0);

    // d2: backpressure for 5 cycles during a burst, scoreboard order/count
    sent = 0; got = 0; hold_v = 0; hold_r = 0; hold_t = 0;
    for (int c = 0; c < 20; c++) begin
      or2 = (c >= 5);
      iv2 = (sent < 6); op2 = 4'd4; a2 = 64'(sent); b2 = 64'd100; t2i = 4'(sent);
      #1;
      if (hold_v) begin
        check("bp_hold_result", r2, hold_r);
        check("bp_hold_tag", t2o, hold_t);
      end
      if (c == 2) begin
        check("bp_ready_low", ir2, 0);
        check("bp_accepts_before_stall", sent, 2);
      end
      hold_v = ov2 && !or2;
      hold_r = r2;
      hold_t = t2o;
      if (ov2 && or2) begin
        if (q.size() == 0) begin
          check("bp_spurious_output", ov2, 0);
        end else begin
          check("bp_order_tag", t2o, q[0]);
          check("bp_order_result", r2, 64'(q[0]) + 64'd100);
          void'(q.pop_front());
          got++;
        end
      end
      if (iv2 && ir2) begin
        q.push_back(4'(sent));
        sent++;
      end
      step();
    end
    iv2 = 0;
    check("bp_count", got, 6);
    check("bp_queue_empty", q.size(), 0);

    // d2: flush with a full, stalled pipe and a new op presented
    or2 = 0; iv2 = 1; op2 = 4'd4; a2 = 64'd1; b2 = 64'd1; t2i = 4'd10;
    step();
    t2i = 4'd11;
    step();
    #1 check("flush_pipe_full", ir2, 0);
    t2i = 4'd12; f2 = 1;
    step();
    f2 = 0; iv2 = 0; or2 = 1;
    check("flush_valid", ov2, 0);
    #1 check("flush_ready", ir2, 1);
    for (int c = 0; c < 4; c++) begin
      step();
      check("flush_no_ghost", ov2, 0);
    end
    iv2 = 1; op2 = 4'd7; a2 = 64'hFF00; b2 = 64'h0FF0; t2i = 4'd13;
    step();
    iv2 = 0;
    check("post_flush_latency", ov2, 0);
    step();
    check("post_flush_valid", ov2, 1);
    check("post_flush_tag", t2o, 4'd13);
    check("post_flush_result", r2, 64'h0F00);

    // Reset for one cycle with d2 full and stalled
    or2 = 0; iv2 = 1; op2 = 4'd4; a2 = 64'd2; b2 = 64'd3; t2i = 4'd14;
    step();
    t2i = 4'd15;
    step();
    check("prerst_valid", ov2, 1);
    rst_n = 0; iv2 = 0;
    step();
    rst_n = 1;
    check("midrst_valid", ov2, 0);
    check("midrst_result", r2, 0);
    check("midrst_tag", t2o, 0);
    check("midrst_d1_result", r1, 0);
    #1 check("midrst_ready", ir2, 1);
    or2 = 1; iv2 = 1; op2 = 4'd6; a2 = 64'd3; b2 = 64'd5; t2i = 4'd2;
    step();
    iv2 = 0;
    check("postrst_latency", ov2, 0);
    step();
    check("postrst_valid", ov2, 1);
    check("postrst_tag", t2o, 4'd2);
    check("postrst_result", r2, 64'hFFFF_FFFF_FFFF_FFFE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
